// File: rtl/sine_pkg.sv
// Shared constants and state encoding for the quarter-wave sine sequencer.
package sine_pkg;
  localparam int DEF_PHASE_W = 9;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_DIV_W   = 16;

  localparam logic [9:0] MIDSCALE = 10'd512;
  localparam logic [6:0] QMAX     = 7'd127;

  typedef enum logic [1:0] {IDLE, RUN, STOP} seq_state_t;
endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Frequency/rate configuration channel (valid/ready).
interface sine_phase_sequencer_if #(
  parameter int PHASE_W = sine_pkg::DEF_PHASE_W,
  parameter int DIV_W   = sine_pkg::DEF_DIV_W
);
  logic               valid;
  logic               ready;
  logic [PHASE_W-1:0] step;
  logic [DIV_W-1:0]   div;

  modport master (output valid, step, div, input ready);
  modport slave  (input valid, step, div, output ready);
endinterface

// File: rtl/sine_phase_sequencer_tick_div.sv
// Sample-rate divider: strobes tick every (div+1) clocks while active, first strobe immediately.
module sample_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = active_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i)   cnt_d = '0;
    else if (tick_o) cnt_d = div_i;
    else             cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sine_phase_sequencer.sv
// Phase accumulator + quadrant mirroring in front of a quarter-wave ROM; config changes
// are deferred to waveform-cycle boundaries so the output never glitches mid-cycle.
module sine_phase_sequencer import sine_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  sine_phase_sequencer_if.slave cfg,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [DATA_W-1:0]   rom_data_i,
  output logic [DATA_W-1:0]   sample_o,
  output logic                sample_valid_o,
  output logic                wrap_o,
  output logic                busy_o
);
  seq_state_t         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, step_q, step_d, pstep_q, pstep_d;
  logic [DIV_W-1:0]   div_q, div_d, pdiv_q, pdiv_d;
  logic               pend_q, pend_d;
  logic               tick, carry, hs, to_idle, apply;
  logic [PHASE_W:0]   sum;
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  idx, addr_q;
  logic [1:0]         vld_pipe_q, neg_pipe_q, wrap_pipe_q;
  logic [DATA_W-1:0]  sample_q;
  logic               sv_q, wrap_q;

  sample_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q != IDLE),
    .div_i    (div_q),
    .tick_o   (tick)
  );

  assign sum       = {1'b0, phase_q} + {1'b0, step_q};
  assign carry     = sum[PHASE_W];
  assign quad      = phase_q[PHASE_W-1:PHASE_W-2];
  assign idx       = phase_q[ADDR_W-1:0];
  assign cfg.ready = !pend_q;
  assign hs        = cfg.valid && !pend_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    to_idle = 1'b0;
    case (state_q)
      IDLE: if (enable_i) begin
        state_d = RUN;
        phase_d = '0;
      end
      RUN:  if (!enable_i) state_d = STOP;
      STOP: begin
        if (enable_i) state_d = RUN;
        else if (tick && (carry || step_q == '0)) begin
          state_d = IDLE;
          to_idle = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tick) phase_d = sum[PHASE_W-1:0];
  end

  // Pending config lands on a wrap, on entry to IDLE, or (if it slipped in at the
  // IDLE transition) as soon as we sit in IDLE.
  always_comb begin
    step_d  = step_q;
    div_d   = div_q;
    pstep_d = pstep_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    apply   = (tick && carry) || to_idle || (state_q == IDLE);
    if (apply && pend_q) begin
      step_d = pstep_q;
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end
    if (hs) begin
      if (state_q == IDLE) begin
        step_d = cfg.step;
        div_d  = cfg.div;
      end else begin
        pstep_d = cfg.step;
        pdiv_d  = cfg.div;
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      step_q      <= PHASE_W'(1);
      div_q       <= '0;
      pstep_q     <= '0;
      pdiv_q      <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      vld_pipe_q  <= '0;
      neg_pipe_q  <= '0;
      wrap_pipe_q <= '0;
      sample_q    <= MIDSCALE;
      sv_q        <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      div_q       <= div_d;
      pstep_q     <= pstep_d;
      pdiv_q      <= pdiv_d;
      pend_q      <= pend_d;
      if (tick) addr_q <= quad[0] ? (QMAX - idx) : idx;
      vld_pipe_q  <= {vld_pipe_q[0], tick};
      neg_pipe_q  <= {neg_pipe_q[0], quad[1]};
      wrap_pipe_q <= {wrap_pipe_q[0], tick & carry};
      // Lower half-wave: 1023-x is just the bitwise complement.
      if (vld_pipe_q[1]) sample_q <= neg_pipe_q[1] ? ~rom_data_i : rom_data_i;
      sv_q        <= vld_pipe_q[1];
      wrap_q      <= vld_pipe_q[1] & wrap_pipe_q[1];
    end
  end

  assign rom_addr_o     = addr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sv_q;
  assign wrap_o         = wrap_q;
  assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed bench for sine_phase_sequencer with a registered quarter-wave ROM model.
module tb_sine_phase_sequencer;
  logic       clk = 1'b0;
  logic       rst, enable;
  logic [6:0] rom_addr;
  logic [9:0] rom_data, sample;
  logic       sample_valid, wrap, busy;
  int         checks = 0, errors = 0;
  int         smp [512];

  sine_phase_sequencer_if cfg_if ();

  sine_phase_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .cfg            (cfg_if),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .wrap_o         (wrap),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // ROM content 515 + 4*addr: spans 515..1023, registered read.
  always @(posedge clk) rom_data <= 10'(515 + 4 * int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_sample(input int ph);
    int q, i, a, d;
    q = (ph >> 7) & 3;
    i = ph & 127;
    a = (q & 1) ? 127 - i : i;
    d = 515 + 4 * a;
    return (q & 2) ? 1023 - d : d;
  endfunction

  // Collects one full waveform cycle of n samples starting at phase 0; optionally offers a
  // config hs_lag clocks after sample hs_idx, and drops enable after sample dis_idx.
  task automatic run_cycle(input int n, input int step, input int div,
                           input int hs_idx, input int hs_lag,
                           input logic [8:0] hs_step, input logic [15:0] hs_div,
                           input bit pend_during, input int dis_idx);
    int ph = 0, got = 0, cyc = 0, last = 0, hs_t = -1;
    while (got < n && cyc < n * (div + 1) + 20) begin
      tick();
      cyc++;
      if (cfg_if.valid) cfg_if.valid = 1'b0;
      if (sample_valid) begin
        smp[got] = int'(sample);
        chk("sample", 32'(sample), 32'(exp_sample(ph)));
        chk("wrap", 32'(wrap), 32'(got == n - 1));
        if (got >= 1) chk("spacing", 32'(cyc - last), 32'(div + 1));
        if (got == n - 4) begin
          chk("busy_late", 32'(busy), 32'd1);
          chk("rdy_late", 32'(cfg_if.ready), 32'(!pend_during));
        end
        if (dis_idx >= 0 && got == n - 2) chk("busy_drain", 32'(busy), 32'd0);
        if (got == dis_idx) enable = 1'b0;
        if (got == hs_idx) hs_t = hs_lag;
        last = cyc;
        ph = (ph + step) % 512;
        got++;
      end
      if (hs_t == 0) begin
        chk("rdy_hs", 32'(cfg_if.ready), 32'd1);
        cfg_if.valid = 1'b1;
        cfg_if.step  = hs_step;
        cfg_if.div   = hs_div;
      end
      if (hs_t >= 0) hs_t--;
    end
    chk("cycle_len", 32'(got), 32'(n));
  endtask

  initial begin
    int sv_cnt;
    rst = 1'b1;
    enable = 1'b0;
    cfg_if.valid = 1'b0;
    cfg_if.step = '0;
    cfg_if.div = '0;
    tick();
    tick();
    chk("rst_sample", 32'(sample), 32'd512);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(cfg_if.ready), 32'd1);
    chk("rst_addr", 32'(rom_addr), 32'd0);

    // Default step=1, div=0; queue step=4/div=3 mid-cycle
    rst = 1'b0;
    enable = 1'b1;
    run_cycle(512, 1, 0, 100, 0, 9'd4, 16'd3, 1'b1, -1);
    chk("c1_s0", 32'(smp[0]), 32'd515);
    chk("c1_peak", 32'(smp[128]), 32'd1023);
    chk("c1_s256", 32'(smp[256]), 32'd508);
    chk("c1_trough", 32'(smp[384]), 32'd0);
    chk("c1_rdy_after_wrap", 32'(cfg_if.ready), 32'd1);

    // step=4 div=3; offer step=8/div=1 exactly on the wrapping tick
    run_cycle(128, 4, 3, 126, 1, 9'd8, 16'd1, 1'b0, -1);
    chk("c2_s0", 32'(smp[0]), 32'd515);
    chk("c2_addr127", 32'(smp[32]), 32'd1023);
    chk("c2_addr123", 32'(smp[33]), 32'd1007);

    // Old step still used for the whole next cycle, pending held
    run_cycle(128, 4, 3, -1, 0, 9'd0, 16'd0, 1'b1, -1);
    run_cycle(64, 8, 1, 10, 0, 9'd1, 16'd0, 1'b1, -1);
    chk("c4_peak", 32'(smp[16]), 32'd1023);

    // Stop request mid-cycle: runs to wrap, then drains two samples
    run_cycle(512, 1, 0, -1, 0, 9'd0, 16'd0, 1'b0, 198);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_final", 32'(sample), 32'd508);
    sv_cnt = 0;
    repeat (6) begin
      tick();
      if (sample_valid) sv_cnt++;
    end
    chk("stop_quiet", 32'(sv_cnt), 32'd0);
    chk("stop_hold", 32'(sample), 32'd508);

    // Reset mid-run with a pending config
    enable = 1'b1;
    repeat (40) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    cfg_if.valid = 1'b1;
    cfg_if.step = 9'd8;
    cfg_if.div = 16'd0;
    chk("pre_rst_rdy", 32'(cfg_if.ready), 32'd1);
    tick();
    cfg_if.valid = 1'b0;
    chk("pend_rdy", 32'(cfg_if.ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_sample", 32'(sample), 32'd512);
    chk("mid_rst_sv", 32'(sample_valid), 32'd0);
    chk("mid_rst_wrap", 32'(wrap), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdy", 32'(cfg_if.ready), 32'd1);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    enable = 1'b0;
    sv_cnt = 0;
    repeat (4) begin
      tick();
      if (sample_valid) sv_cnt++;
    end
    chk("post_rst_quiet", 32'(sv_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Pending step=8 must be gone: defaults step=1, div=0 again
    enable = 1'b1;
    run_cycle(512, 1, 0, -1, 0, 9'd0, 16'd0, 1'b0, -1);
    chk("post_rst_peak", 32'(smp[128]), 32'd1023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
